// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - pipeline op/response and data-memory request bus for lsu_mem_ctrl
// master is the controller's view; slave is the pipeline-plus-memory environment.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              lsu_valid;
  logic              lsu_ready;
  logic              lsu_we;
  logic [2:0]        lsu_funct3;
  logic [ADDR_W-1:0] lsu_addr;
  logic [31:0]       lsu_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [1:0]        resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    input  lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata, mem_ack, mem_rdata,
    output lsu_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata, mem_ack, mem_rdata,
    input  lsu_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - MEM-stage load/store initiator toward the data memory
// Accepts one op in IDLE, issues a word request, formats load data and reports a status code.
module lsu_mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_ctrl_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e state_q, state_d;

  logic              mem_req_q,    mem_req_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [3:0]        mem_be_q,     mem_be_d;
  logic [31:0]       mem_wdata_q,  mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [1:0]        resp_err_q,   resp_err_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [1:0]        off_q,        off_d;
  logic [2:0]        f3_q,         f3_d;

  logic        f3_illegal;
  logic        misaligned;
  logic        timeout_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Unsigned loads are meaningless for stores, so SBU/SHU encodings report illegal funct3.
  always_comb begin
    f3_illegal = 1'b0;
    misaligned = 1'b0;
    case (bus.lsu_funct3)
      3'b000: misaligned = 1'b0;
      3'b001: misaligned = bus.lsu_addr[0];
      3'b010: misaligned = |bus.lsu_addr[1:0];
      3'b100: f3_illegal = bus.lsu_we;
      3'b101: begin
        f3_illegal = bus.lsu_we;
        misaligned = bus.lsu_addr[0];
      end
      default: f3_illegal = 1'b1;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = bus.lsu_wdata;
    case (bus.lsu_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << bus.lsu_addr[1:0];
        st_wdata = {4{bus.lsu_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = bus.lsu_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{bus.lsu_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = bus.lsu_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = bus.mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.lsu_valid) begin
          state_d = (f3_illegal || misaligned) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.mem_ack || timeout_hit) begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A same-cycle ack takes priority over the timeout, so it is tested first.
  always_comb begin
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    f3_d         = f3_q;
    case (state_q)
      S_IDLE: begin
        if (bus.lsu_valid) begin
          if (f3_illegal || misaligned) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = f3_illegal ? 2'b11 : 2'b01;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = bus.lsu_we;
            mem_addr_d  = {bus.lsu_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = bus.lsu_we ? st_be : 4'b0000;
            mem_wdata_d = bus.lsu_we ? st_wdata : '0;
            off_d       = bus.lsu_addr[1:0];
            f3_d        = bus.lsu_funct3;
            cnt_d       = '0;
          end
        end
      end
      S_BUSY: begin
        if (bus.mem_ack) begin
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_be_d     = 4'b0000;
          resp_valid_d = 1'b1;
          resp_err_d   = 2'b00;
          resp_rdata_d = mem_we_q ? '0 : ld_data;
        end else if (timeout_hit) begin
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_be_d     = 4'b0000;
          resp_valid_d = 1'b1;
          resp_err_d   = 2'b10;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: resp_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 2'b00;
      cnt_q        <= '0;
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
    end else begin
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
    end
  end

  assign bus.lsu_ready  = (state_q == S_IDLE);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed and randomized self-checking bench for lsu_mem_ctrl
// Expected results come from a byte-level memory model and the load/store rules, not from the RTL.
module tb_lsu_mem_ctrl;

  localparam int ADDR_W = 32;
  localparam int TO     = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ref_mem follows the architectural effect of each op; bus_mem follows what the DUT actually wrote.
  logic [31:0] ref_mem [int];
  logic [31:0] bus_mem [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic void touch(input int idx);
    logic [31:0] v;
    if (!ref_mem.exists(idx)) begin
      v = $urandom;
      ref_mem[idx] = v;
      bus_mem[idx] = v;
    end
  endfunction

  task automatic idle_ack(input string tag);
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = $urandom;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    @(negedge clk);
    check({tag, ":idle_ack_resp"}, bus.resp_valid, 0);
    check({tag, ":idle_ack_req"},  bus.mem_req,    0);
    check({tag, ":idle_ack_rdy"},  bus.lsu_ready,  1);
  endtask

  // waits < 0 means the memory never acknowledges.
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int waits);
    int          bytes, off, widx, midx, exp_lat, exp_reqs;
    int          req_cycle, req_count, resp_cycle, ready_bad, stable_bad;
    logic        illegal, mis;
    logic [1:0]  exp_err, got_err;
    logic [31:0] exp_rdata, exp_be, exp_wdata, word, mask, tmp, got_rdata;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_be;
    logic        snap_we;

    off   = int'(addr % 4);
    bytes = 1 << f3[1:0];
    widx  = int'(addr >> 2);
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
    mis     = !illegal && ((off % bytes) != 0);
    touch(widx);
    word = ref_mem[widx];

    if (illegal)                        exp_err = 2'b11;
    else if (mis)                       exp_err = 2'b01;
    else if (waits < 0 || waits >= TO)  exp_err = 2'b10;
    else                                exp_err = 2'b00;
    exp_lat  = (illegal || mis) ? 1 : (exp_err == 2'b10 ? TO + 1 : waits + 2);
    exp_reqs = (illegal || mis) ? 0 : (exp_err == 2'b10 ? TO : waits + 1);

    exp_rdata = '0;
    if (exp_err == 2'b00 && !we) begin
      mask      = (bytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * bytes)) - 1);
      exp_rdata = (word >> (8 * off)) & mask;
      if (!f3[2] && bytes < 4 && exp_rdata[8 * bytes - 1]) exp_rdata = exp_rdata | ~mask;
    end
    exp_be    = ((32'h1 << bytes) - 1) << off;
    exp_wdata = (bytes == 1) ? {24'b0, wd[7:0]} * 32'h0101_0101 :
                (bytes == 2) ? {16'b0, wd[15:0]} * 32'h0001_0001 : wd;
    if (exp_err == 2'b00 && we) begin
      tmp = ref_mem[widx];
      for (int i = 0; i < bytes; i++) tmp[8 * (off + i) +: 8] = wd[8 * i +: 8];
      ref_mem[widx] = tmp;
    end

    @(negedge clk);
    check({tag, ":ready_before"}, bus.lsu_ready, 1);
    bus.lsu_valid  = 1'b1;
    bus.lsu_we     = we;
    bus.lsu_funct3 = f3;
    bus.lsu_addr   = addr;
    bus.lsu_wdata  = wd;
    @(posedge clk);
    #1;
    bus.lsu_valid  = 1'b0;
    bus.lsu_we     = 1'($urandom);
    bus.lsu_funct3 = 3'($urandom);
    bus.lsu_addr   = $urandom;
    bus.lsu_wdata  = $urandom;

    req_cycle = 0; req_count = 0; resp_cycle = 0; ready_bad = 0; stable_bad = 0;
    got_err = 2'b00; got_rdata = '0;
    snap_addr = '0; snap_wdata = '0; snap_be = '0; snap_we = 1'b0;
    for (int c = 1; c <= TO + 4 && resp_cycle == 0; c++) begin
      @(negedge clk);
      if (bus.lsu_ready) ready_bad++;
      if (bus.resp_valid) begin
        resp_cycle = c;
        got_err    = bus.resp_err;
        got_rdata  = bus.resp_rdata;
      end
      if (bus.mem_req) begin
        req_count++;
        if (req_cycle == 0) begin
          req_cycle  = c;
          snap_we    = bus.mem_we;
          snap_addr  = bus.mem_addr;
          snap_be    = bus.mem_be;
          snap_wdata = bus.mem_wdata;
          check({tag, ":mem_we"},   {31'b0, bus.mem_we}, {31'b0, we});
          check({tag, ":mem_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
          check({tag, ":mem_be"},   {28'b0, bus.mem_be}, we ? exp_be : 32'h0);
          if (we) check({tag, ":mem_wdata"}, bus.mem_wdata, exp_wdata);
        end else if (bus.mem_we !== snap_we || bus.mem_addr !== snap_addr ||
                     bus.mem_be !== snap_be || bus.mem_wdata !== snap_wdata) begin
          stable_bad++;
        end
        if (waits >= 0 && c == waits + 1) begin
          midx = int'(bus.mem_addr >> 2);
          touch(midx);
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = bus_mem[midx];
          if (bus.mem_we) begin
            tmp = bus_mem[midx];
            for (int b = 0; b < 4; b++)
              if (bus.mem_be[b]) tmp[8 * b +: 8] = bus.mem_wdata[8 * b +: 8];
            bus_mem[midx] = tmp;
          end
          @(posedge clk);
          #1;
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end
    end

    check({tag, ":latency"},   resp_cycle, exp_lat);
    check({tag, ":resp_err"},  {30'b0, got_err}, {30'b0, exp_err});
    check({tag, ":resp_rdata"}, got_rdata, exp_rdata);
    check({tag, ":req_cycles"}, req_count, exp_reqs);
    check({tag, ":ready_low"},  ready_bad, 0);
    if (exp_reqs > 1) check({tag, ":req_stable"}, stable_bad, 0);
    @(negedge clk);
    check({tag, ":valid_drop"}, bus.resp_valid, 0);
    check({tag, ":ready_after"}, bus.lsu_ready, 1);
    check({tag, ":req_after"},   bus.mem_req, 0);
    check({tag, ":rdata_hold"},  bus.resp_rdata, exp_rdata);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r, waits;
    logic [31:0] a;
    bus.lsu_valid  = 1'b0;
    bus.lsu_we     = 1'b0;
    bus.lsu_funct3 = 3'b000;
    bus.lsu_addr   = '0;
    bus.lsu_wdata  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;

    repeat (2) @(negedge clk);
    check("rst:ready",      bus.lsu_ready, 1);
    check("rst:mem_req",    bus.mem_req, 0);
    check("rst:mem_we",     bus.mem_we, 0);
    check("rst:mem_addr",   bus.mem_addr, 0);
    check("rst:mem_be",     {28'b0, bus.mem_be}, 0);
    check("rst:mem_wdata",  bus.mem_wdata, 0);
    check("rst:resp_valid", bus.resp_valid, 0);
    check("rst:resp_rdata", bus.resp_rdata, 0);
    check("rst:resp_err",   {30'b0, bus.resp_err}, 0);
    rst_n = 1'b1;

    run_op("sb_1003", 1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 0);

    ref_mem[32'h2002 >> 2] = 32'h12F4_5678;
    bus_mem[32'h2002 >> 2] = 32'h12F4_5678;
    run_op("lb_2002",  1'b0, 3'b000, 32'h2002, 32'h0, 3);
    run_op("lbu_2002", 1'b0, 3'b100, 32'h2002, 32'h0, 3);
    run_op("lh_2002",  1'b0, 3'b001, 32'h2002, 32'h0, 0);
    run_op("lhu_2002", 1'b0, 3'b101, 32'h2002, 32'h0, 1);

    run_op("lw_mis",  1'b0, 3'b010, 32'h3001, 32'h0, 0);
    run_op("f3_011",  1'b0, 3'b011, 32'h3000, 32'h0, 0);
    run_op("sb_f3_4", 1'b1, 3'b100, 32'h3000, 32'h55, 0);
    run_op("sh_mis",  1'b1, 3'b001, 32'h3003, 32'h1234, 0);

    run_op("lw_timeout", 1'b0, 3'b010, 32'h500, 32'h0, -1);
    run_op("lw_ack16",   1'b0, 3'b010, 32'h504, 32'h0, TO - 1);

    idle_ack("b2b");
    run_op("sw_40", 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 0);
    run_op("lw_40", 1'b0, 3'b010, 32'h40, 32'h0, 0);
    check("lw_40:model_word", ref_mem[32'h40 >> 2], 32'hDEAD_BEEF);

    // Reset asserted mid-BUSY, away from any clock edge.
    @(negedge clk);
    bus.lsu_valid  = 1'b1;
    bus.lsu_we     = 1'b1;
    bus.lsu_funct3 = 3'b010;
    bus.lsu_addr   = 32'h80;
    bus.lsu_wdata  = 32'hCAFE_F00D;
    @(posedge clk);
    #1 bus.lsu_valid = 1'b0;
    @(negedge clk);
    check("midrst:req_before", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst:req_async", bus.mem_req, 0);
    check("midrst:ready",     bus.lsu_ready, 1);
    check("midrst:be",        {28'b0, bus.mem_be}, 0);
    check("midrst:addr",      bus.mem_addr, 0);
    check("midrst:wdata",     bus.mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    r = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_req || !bus.lsu_ready) r++;
    end
    check("midrst:quiet_after", r, 0);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom % 10);
      if (r < 6)       waits = r % 4;
      else if (r == 6) waits = -1;
      else if (r == 7) waits = TO - 1;
      else             waits = int'($urandom % 8);
      a = 32'h100 + ($urandom % 8) * 4 + ($urandom % 4);
      if ($urandom % 4 == 0) idle_ack($sformatf("rnd%0d", i));
      run_op($sformatf("rnd%0d", i), 1'($urandom), 3'($urandom), a, $urandom, waits);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator in the MEM stage of the RISC-V pipeline; the requester-side counterpart of the data-memory responder.
- Accepts one load/store op from the pipeline per transaction.
- Checks alignment and funct3, drives a word-addressed request with byte enables and lane-replicated write data, then waits for the memory acknowledge.
- Returns lane-extracted, sign/zero-extended load data with a status code. The pipeline stalls on lsu_ready low.

Parameters:
- ADDR_W, 32, width of lsu_addr/mem_addr.
- TIMEOUT, 16, max cycles in BUSY without mem_ack before a bus error; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- lsu_valid  input  1  pipeline op valid
- lsu_ready  output  1  block can accept an op (high only in IDLE)
- lsu_we  input  1  1 = store, 0 = load
- lsu_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- lsu_addr  input  ADDR_W  byte address
- lsu_wdata  input  32  store data (low bytes significant)
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  formatted load data; 0 for stores and errors
- resp_err  output  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal funct3
- mem_req  output  1  request to data memory
- mem_we  output  1  write request
- mem_addr  output  ADDR_W  word-aligned address, low 2 bits forced to 0
- mem_be  output  4  byte enables; 0000 for loads
- mem_wdata  output  32  lane-replicated store data
- mem_ack  input  1  memory completes the request this cycle
- mem_rdata  input  32  read word, valid when mem_ack=1

Behaviour:
- States: IDLE, BUSY, RESP. Encoding is free.
- All state and outputs are registered except lsu_ready = (state==IDLE).
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_err, timeout counter all 0.
  - Reset mid-BUSY drops mem_req immediately. No response is produced.
- IDLE, accept on lsu_valid & lsu_ready:
  - funct3 in {011, 110, 111} -> RESP with err=11. No memory request.
  - Misaligned access -> RESP with err=01. No memory request. Rules: H/HU/SH need addr[0]=0; W/SW need addr[1:0]=00; for stores, funct3 100/101 counts as illegal (err=11).
  - Otherwise -> BUSY. Register mem_req=1, mem_we=lsu_we, mem_addr={addr[ADDR_W-1:2],2'b00}, lane data/enables, offset=addr[1:0], funct3. Clear the counter.
- Store lanes:
  - SB: mem_wdata={4{wdata[7:0]}}, mem_be=0001<<offset.
  - SH: mem_wdata={2{wdata[15:0]}}, mem_be=offset[1]?1100:0011.
  - SW: mem_wdata=wdata, mem_be=1111.
- BUSY:
  - mem_req and all mem_* outputs are held stable until mem_ack.
  - On mem_ack: drop mem_req/mem_we/mem_be, go to RESP with err=00.
  - For loads, capture resp_rdata:
    - byte = mem_rdata[8*offset +: 8]; half = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0].
    - 000 sign-extends byte; 100 zero-extends byte.
    - 001 sign-extends half; 101 zero-extends half.
    - 010 passes the full word.
  - No ack: counter increments each cycle. When counter == TIMEOUT-1 and TIMEOUT != 0, drop mem_req, go to RESP with err=10, resp_rdata=0.
  - mem_ack in the same cycle as the timeout: the ack wins (normal completion).
- RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err, then IDLE. resp_valid deasserts the next cycle; resp_rdata/resp_err hold until the next response.
- mem_ack while in IDLE or RESP is ignored.
- Latency (accept edge = cycle 0):
  - mem_req high in cycle 1.
  - Zero-wait ack in cycle 1 gives resp_valid in cycle 2.
  - Each wait cycle adds 1.
  - Error ops give resp_valid in cycle 1.
- Back-to-back: next accept is possible in the cycle after RESP (IDLE). Maximum throughput is one op per 3 cycles.

Test Plan:
- Reset: hold rst_n=0 mid-BUSY with mem_req=1 -> mem_req drops asynchronously; after release state is IDLE, lsu_ready=1, all outputs 0, no resp_valid.
- SB addr=0x1003 wdata=0x000000A5, ack in cycle 1 -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1; resp_valid cycle 2, err=00, rdata=0.
- LB/LBU addr=0x2002, mem_rdata=0x12F45678 acked after 3 wait cycles -> LB rdata=0xFFFFFFF4, LBU rdata=0x000000F4, resp_valid cycle 5; LH addr=0x2002 -> 0x000012F4.
- Misaligned: LW addr=0x3001 -> resp_valid cycle 1, err=01, mem_req never asserted; funct3=011 -> err=11; SB with funct3=100 -> err=11.
- Timeout, TIMEOUT=16, no ack -> mem_req high cycles 1-16, resp_valid cycle 17 with err=10; repeat with ack in cycle 16 -> err=00 with data.
- Back-to-back SW then LW to 0x40, memory model returns the written word 0xDEADBEEF -> LW rdata=0xDEADBEEF, lsu_ready low exactly during BUSY/RESP, no ack accepted while IDLE.
